// File: rtl/nes_joypad_ctrl.sv
// nes_joypad_ctrl: maps a 32-bit USB keycode word ({k3,k2,k1,k0}) onto two
// NES standard-controller shift registers served over the $4016/$4017
// strobe/serial-read protocol.
// Optional feature macro: TURBO_EN adds a turbo phase counter and turbo A/B keys.
module nes_joypad_ctrl #(
    parameter int unsigned TURBO_DIV = 833333
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] keycode,
    input  logic        strobe,
    input  logic        rd_p1,
    input  logic        rd_p2,
    output logic        p1_data,
    output logic        p2_data,
    output logic [7:0]  p1_buttons,
    output logic [7:0]  p2_buttons
);

    localparam int unsigned BW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned KW = 32;
    localparam int unsigned TW = 20;
    localparam logic [CW-1:0] CNT_MAX = CW'(8);

    logic [BW-1:0] p1_dec_c;
    logic [BW-1:0] p2_dec_c;
    logic [BW-1:0] sh1;
    logic [BW-1:0] sh2;
    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;
    logic          rd1_q;
    logic          rd2_q;
    logic          shift1_c;
    logic          shift2_c;

    // True when any of the four keycode bytes equals code (codes are never 0x00)
    function automatic logic key_hit(input logic [KW-1:0] kc, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (kc[8*i +: 8] == code) hit = 1'b1;
        end
        return hit;
    endfunction

`ifdef TURBO_EN
    logic [TW-1:0] turbo_cnt;
    logic          turbo_phase;

    // Free-running turbo divider: phase flips once every TURBO_DIV cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else if (turbo_cnt == TW'(TURBO_DIV - 1)) begin
            turbo_cnt   <= '0;
            turbo_phase <= ~turbo_phase;
        end else begin
            turbo_cnt   <= turbo_cnt + TW'(1);
        end
    end
`else
    logic [TW-1:0] unused_turbo_div;
    assign unused_turbo_div = TW'(TURBO_DIV);
`endif

    // Key map decode for both ports (bit0 A .. bit7 Right)
    always_comb begin
        p1_dec_c    = '0;
        p2_dec_c    = '0;
        p1_dec_c[0] = key_hit(keycode, 8'h0E);
        p1_dec_c[1] = key_hit(keycode, 8'h0D);
        p1_dec_c[2] = key_hit(keycode, 8'h0A);
        p1_dec_c[3] = key_hit(keycode, 8'h0B);
        p1_dec_c[4] = key_hit(keycode, 8'h1A);
        p1_dec_c[5] = key_hit(keycode, 8'h16);
        p1_dec_c[6] = key_hit(keycode, 8'h04);
        p1_dec_c[7] = key_hit(keycode, 8'h07);
        p2_dec_c[0] = key_hit(keycode, 8'h5A);
        p2_dec_c[1] = key_hit(keycode, 8'h59);
        p2_dec_c[2] = key_hit(keycode, 8'h5C);
        p2_dec_c[3] = key_hit(keycode, 8'h5D);
        p2_dec_c[4] = key_hit(keycode, 8'h52);
        p2_dec_c[5] = key_hit(keycode, 8'h51);
        p2_dec_c[6] = key_hit(keycode, 8'h50);
        p2_dec_c[7] = key_hit(keycode, 8'h4F);
`ifdef TURBO_EN
        p1_dec_c[0] = p1_dec_c[0] | (turbo_phase & key_hit(keycode, 8'h0C));
        p1_dec_c[1] = p1_dec_c[1] | (turbo_phase & key_hit(keycode, 8'h18));
        p2_dec_c[0] = p2_dec_c[0] | (turbo_phase & key_hit(keycode, 8'h60));
        p2_dec_c[1] = p2_dec_c[1] | (turbo_phase & key_hit(keycode, 8'h5F));
`endif
    end

    // Registered button state and read-enable history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_buttons <= '0;
            p2_buttons <= '0;
            rd1_q      <= 1'b0;
            rd2_q      <= 1'b0;
        end else begin
            p1_buttons <= p1_dec_c;
            p2_buttons <= p2_dec_c;
            rd1_q      <= rd_p1;
            rd2_q      <= rd_p2;
        end
    end

    // Shift on the falling edge of a read pulse, only while strobe is low
    assign shift1_c = rd1_q & ~rd_p1 & ~strobe;
    assign shift2_c = rd2_q & ~rd_p2 & ~strobe;

    // Port 1 shift register: load while strobed, shift in ones after each read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh1  <= '0;
            cnt1 <= '0;
        end else if (strobe) begin
            sh1  <= p1_buttons;
            cnt1 <= '0;
        end else if (shift1_c) begin
            sh1  <= {1'b1, sh1[BW-1:1]};
            if (cnt1 != CNT_MAX) cnt1 <= cnt1 + CW'(1);
        end
    end

    // Port 2 shift register, independent of port 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh2  <= '0;
            cnt2 <= '0;
        end else if (strobe) begin
            sh2  <= p2_buttons;
            cnt2 <= '0;
        end else if (shift2_c) begin
            sh2  <= {1'b1, sh2[BW-1:1]};
            if (cnt2 != CNT_MAX) cnt2 <= cnt2 + CW'(1);
        end
    end

    assign p1_data = sh1[0];
    assign p2_data = sh2[0];

endmodule

// File: tb/tb_nes_joypad_ctrl.sv
// Testbench for nes_joypad_ctrl: directed protocol scenarios plus randomized
// keycode/read traffic against a controller-level reference model.
module tb_nes_joypad_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] keycode;
    logic        strobe;
    logic        rd_p1;
    logic        rd_p2;
    logic        p1_data;
    logic        p2_data;
    logic [7:0]  p1_buttons;
    logic [7:0]  p2_buttons;

    int checks   = 0;
    int failures = 0;

    // Reference model: buttons latched at strobe and number of reads taken
    logic [7:0] lat1, lat2;
    int         rc1, rc2;

    logic [7:0] map1 [8] = '{8'h0E, 8'h0D, 8'h0A, 8'h0B, 8'h1A, 8'h16, 8'h04, 8'h07};
    logic [7:0] map2 [8] = '{8'h5A, 8'h59, 8'h5C, 8'h5D, 8'h52, 8'h51, 8'h50, 8'h4F};
    logic [7:0] s [16];

    nes_joypad_ctrl #(.TURBO_DIV(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .keycode    (keycode),
        .strobe     (strobe),
        .rd_p1      (rd_p1),
        .rd_p2      (rd_p2),
        .p1_data    (p1_data),
        .p2_data    (p2_data),
        .p1_buttons (p1_buttons),
        .p2_buttons (p2_buttons)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dec(input logic [31:0] kc, input int port);
        logic [7:0] b;
        logic [7:0] code;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            code = (port == 1) ? map1[k] : map2[k];
            for (int i = 0; i < 4; i++)
                if (kc[8*i +: 8] == code) b[k] = 1'b1;
        end
        return b;
    endfunction

    function automatic logic exp_bit(input logic [7:0] lat, input int rc);
        return (rc < 8) ? lat[rc] : 1'b1;
    endfunction

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        if ($urandom_range(0, 1) == 1) b = (($urandom_range(0, 1) == 1) ? map1[$urandom_range(0, 7)]
                                                                           : map2[$urandom_range(0, 7)]);
        else b = 8'($urandom_range(0, 255));
        if (b == 8'h0C || b == 8'h18 || b == 8'h5F || b == 8'h60) b = 8'h00;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_strobe(input int n);
        strobe = 1'b1;
        repeat (n) tick();
        strobe = 1'b0;
        tick();
        lat1 = dec(keycode, 1);
        lat2 = dec(keycode, 2);
        rc1  = 0;
        rc2  = 0;
    endtask

    // One CPU read pulse on either/both ports, holding rd high for hold cycles
    task automatic read(input bit on1, input bit on2, input int hold);
        chk("p1_data", 8'(p1_data), 8'(exp_bit(lat1, rc1)));
        chk("p2_data", 8'(p2_data), 8'(exp_bit(lat2, rc2)));
        rd_p1 = on1;
        rd_p2 = on2;
        repeat (hold) tick();
        chk("p1_data_hold", 8'(p1_data), 8'(exp_bit(lat1, rc1)));
        chk("p2_data_hold", 8'(p2_data), 8'(exp_bit(lat2, rc2)));
        rd_p1 = 1'b0;
        rd_p2 = 1'b0;
        tick();
        if (on1) rc1++;
        if (on2) rc2++;
    endtask

    initial begin
        logic [7:0] prev_a;
        logic [7:0] new_a;
        logic [31:0] kc;
        int r;

        reset_n = 1'b0;
        keycode = '0;
        strobe  = 1'b0;
        rd_p1   = 1'b0;
        rd_p2   = 1'b0;
        lat1 = '0; lat2 = '0; rc1 = 0; rc2 = 0;
        #12;
        chk("rst_p1_data", 8'(p1_data), 8'h00);
        chk("rst_p2_data", 8'(p2_data), 8'h00);
        chk("rst_p1_buttons", p1_buttons, 8'h00);
        chk("rst_p2_buttons", p2_buttons, 8'h00);
        tick();
        reset_n = 1'b1;
        tick();

        // Port 1: A + Up, ten reads
        keycode = 32'h0000_0E1A;
        tick();
        do_strobe(3);
        chk("t1_p1_buttons", p1_buttons, 8'h11);
        for (int i = 0; i < 10; i++) read(1'b1, 1'b0, 2);

        // Port 2: A + Right, ten reads
        keycode = 32'h4F5A_0000;
        tick();
        do_strobe(2);
        chk("t2_p1_buttons", p1_buttons, 8'h00);
        chk("t2_p2_buttons", p2_buttons, 8'h81);
        for (int i = 0; i < 10; i++) read(1'b0, 1'b1, 2);

        // Strobe held high: data tracks decode, reads do not shift
        strobe  = 1'b1;
        keycode = '0;
        tick();
        tick();
        prev_a = 8'h00;
        for (int i = 0; i < 5; i++) begin
            keycode = (i % 2 == 0) ? 32'h0000_000E : 32'h0;
            new_a   = (i % 2 == 0) ? 8'h01 : 8'h00;
            rd_p1 = 1'b1;
            tick();
            chk("t3_buttons_a", 8'(p1_buttons[0]), new_a);
            chk("t3_data_lag", 8'(p1_data), prev_a);
            rd_p1 = 1'b0;
            tick();
            chk("t3_data_follow", 8'(p1_data), new_a);
            prev_a = new_a;
        end
        strobe = 1'b0;
        tick();
        lat1 = 8'h01; lat2 = 8'h00; rc1 = 0; rc2 = 0;
        read(1'b1, 1'b0, 1);
        read(1'b1, 1'b0, 1);

        // Strobe falls on the same cycle as a read falling edge: shift the loaded value
        keycode = 32'h0000_0D0E;
        tick();
        strobe = 1'b1;
        rd_p1  = 1'b1;
        tick();
        tick();
        strobe = 1'b0;
        rd_p1  = 1'b0;
        tick();
        lat1 = 8'h03; lat2 = 8'h00; rc1 = 1; rc2 = 0;
        read(1'b1, 1'b0, 1);
        read(1'b1, 1'b0, 3);

        // Key change after strobe is invisible until the next strobe
        keycode = 32'h0000_0E00;
        tick();
        do_strobe(2);
        keycode = 32'h0000_0007;
        tick();
        tick();
        chk("t4_p1_buttons", p1_buttons, 8'h80);
        for (int i = 0; i < 8; i++) read(1'b1, 1'b0, 2);
        do_strobe(2);
        for (int i = 0; i < 9; i++) read(1'b1, 1'b0, 2);

        // Asynchronous reset mid-sequence
        keycode = 32'h5A5D_0B0E;
        tick();
        do_strobe(2);
        for (int i = 0; i < 3; i++) read(1'b1, 1'b0, 2);
        chk("t5_pre_p1_data", 8'(p1_data), 8'h01);
        chk("t5_pre_p2_data", 8'(p2_data), 8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_p1_data", 8'(p1_data), 8'h00);
        chk("t5_rst_p2_data", 8'(p2_data), 8'h00);
        chk("t5_rst_p1_buttons", p1_buttons, 8'h00);
        chk("t5_rst_p2_buttons", p2_buttons, 8'h00);
        tick();
        reset_n = 1'b1;
        lat1 = 8'h00; lat2 = 8'h00; rc1 = 0; rc2 = 0;
        tick();
        chk("t5_post_p1_buttons", p1_buttons, 8'h09);
        chk("t5_post_p2_buttons", p2_buttons, 8'h09);
        for (int i = 0; i < 10; i++) read(1'b1, 1'b1, 2);

        // Randomized keycodes and read traffic
        for (int it = 0; it < 20; it++) begin
            kc = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
            keycode = kc;
            tick();
            do_strobe(int'($urandom_range(2, 4)));
            chk("rnd_p1_buttons", p1_buttons, dec(kc, 1));
            chk("rnd_p2_buttons", p2_buttons, dec(kc, 2));
            for (int j = 0; j < 12; j++) begin
                r = int'($urandom_range(1, 3));
                read(r[0], r[1], int'($urandom_range(1, 4)));
            end
        end

        // Turbo A key with strobe held
        keycode = 32'h0000_000C;
        strobe  = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            s[i] = 8'(p1_buttons[0]);
            tick();
        end
`ifdef TURBO_EN
        for (int i = 0; i < 12; i++) chk("t6_turbo_toggle", s[i + 4], s[i] ^ 8'h01);
`else
        for (int i = 0; i < 16; i++) chk("t6_turbo_off", s[i], 8'h00);
`endif
        strobe = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
